vid_sprite_line_scan: RTL and testbench



---
 rtl/vid_sprite_pkg.sv | 20 ++
 rtl/vid_sprite_vis_cmp.sv | 27 ++
 rtl/vid_sprite_line_scan.sv | 159 +++++++++++++++
 tb/tb_vid_sprite_line_scan.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vid_sprite_pkg.sv
// Shared definitions for the per-scanline sprite evaluator: attribute
// entry field positions, line width and the scan FSM state type.
package vid_sprite_pkg;

    localparam int unsigned LINE_W = 11;

    // Attribute entry layout (64 bits)
    localparam int unsigned X_LSB  = 0;
    localparam int unsigned Y_LSB  = 11;
    localparam int unsigned H_LSB  = 22;
    localparam int unsigned H_W    = 6;
    localparam int unsigned EN_BIT = 31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_t;

endpackage

// File: rtl/vid_sprite_vis_cmp.sv
// Combinational vertical visibility test of one attribute entry against
// the current scanline. The 11-bit subtraction wraps, so sprites straddle
// the bottom/top of the 2048-line space naturally.
module vid_sprite_vis_cmp
    import vid_sprite_pkg::*;
(
    input  logic [63:0]       i_entry,
    input  logic [LINE_W-1:0] i_line,
    output logic              o_visible
);

    logic [LINE_W-1:0] w_y;
    logic [H_W-1:0]    w_h_m1;
    logic [LINE_W-1:0] w_dy;
    logic              w_unused_bits;

    assign w_y           = i_entry[Y_LSB +: LINE_W];
    assign w_h_m1        = i_entry[H_LSB +: H_W];
    assign w_unused_bits = &{1'b0, i_entry[63:32], i_entry[30:28], i_entry[X_LSB +: LINE_W]};

    // Row offset of the line inside the sprite, modulo 2048
    always_comb begin
        w_dy      = i_line - w_y;
        o_visible = i_entry[EN_BIT] && (w_dy <= LINE_W'(w_h_m1));
    end

endmodule

// File: rtl/vid_sprite_line_scan.sv
// Per-scanline sprite evaluator. On line_start it walks all attribute
// entries in index order, builds the visible list for the pixel fetch
// engine and pulses done. Pipeline: address (k+1), data (k+2), list
// write (k+3), cycles counted from the line_start cycle.
// Optional build macro: SPRITE_SCAN_EARLY_STOP_EN (stop scanning once a
// visible entry finds the list already full).
module vid_sprite_line_scan
    import vid_sprite_pkg::*;
#(
    parameter int unsigned NUM_SPRITES  = 256,
    parameter int unsigned MAX_PER_LINE = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            line_start,
    input  logic [LINE_W-1:0]               line_num,
    output logic                            mem_en,
    output logic [7:0]                      mem_addr,
    input  logic [63:0]                     mem_q,
    output logic                            list_we,
    output logic [$clog2(MAX_PER_LINE)-1:0] list_idx,
    output logic [63:0]                     list_data,
    output logic [7:0]                      list_sprite,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(MAX_PER_LINE):0]   count,
    output logic                            overflow
);

    localparam int unsigned IW = $clog2(MAX_PER_LINE);
    localparam int unsigned CW = IW + 1;
    localparam logic [7:0]  LAST_ADDR = 8'(NUM_SPRITES - 1);

    scan_state_t   r_state, w_state_nxt;
    logic          w_finish;
    logic          r_drain;
    logic [7:0]    r_addr;
    logic [LINE_W-1:0] r_line;
    logic          r_p1_valid;
    logic [7:0]    r_p1_idx;
    logic          r_p2_vis;
    logic [7:0]    r_p2_idx;
    logic [63:0]   r_p2_data;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic          r_done;
    logic          w_vis;
    logic          w_full;
    logic          w_stop;

    vid_sprite_vis_cmp u_cmp (
        .i_entry   (mem_q),
        .i_line    (r_line),
        .o_visible (w_vis)
    );

    assign w_full = (r_cnt == CW'(MAX_PER_LINE));

    assign mem_en      = (r_state == ST_SCAN);
    assign mem_addr    = r_addr;
    assign list_we     = r_p2_vis && !w_full && !line_start;
    assign list_idx    = r_cnt[IW-1:0];
    assign list_data   = r_p2_data;
    assign list_sprite = r_p2_idx;
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign count       = r_cnt;
    assign overflow    = r_ovf;

`ifdef SPRITE_SCAN_EARLY_STOP_EN
    // A write landing this cycle fills the list before this entry's turn
    logic w_full_eff;
    assign w_full_eff = w_full || ((r_cnt == CW'(MAX_PER_LINE - 1)) && list_we);
    assign w_stop     = (r_state == ST_SCAN) && r_p1_valid && w_vis && w_full_eff && !line_start;
`else
    assign w_stop = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; line_start from any state (re)starts the scan
    always_comb begin
        w_state_nxt = r_state;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (line_start) w_state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                if (line_start)                w_state_nxt = ST_SCAN;
                else if (w_stop)               w_state_nxt = ST_DRAIN;
                else if (r_addr == LAST_ADDR)  w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (line_start) w_state_nxt = ST_SCAN;
                else if (r_drain) begin
                    w_state_nxt = ST_IDLE;
                    w_finish    = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Address sequencing, drain timer, latched line and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_line  <= '0;
            r_drain <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done  <= w_finish;
            r_drain <= (r_state == ST_DRAIN) && !r_drain && !line_start;
            if (line_start) begin
                r_addr <= '0;
                r_line <= line_num;
            end else if (r_state == ST_SCAN && w_state_nxt == ST_SCAN) begin
                r_addr <= r_addr + 8'd1;
            end
        end
    end

    // Read-data tag and registered compare; line_start flushes in-flight entries
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p1_valid <= 1'b0;
            r_p1_idx   <= '0;
            r_p2_vis   <= 1'b0;
            r_p2_idx   <= '0;
            r_p2_data  <= '0;
        end else begin
            r_p1_valid <= mem_en && !line_start && !w_stop;
            r_p1_idx   <= r_addr;
            r_p2_vis   <= r_p1_valid && w_vis && !line_start && !w_stop;
            r_p2_idx   <= r_p1_idx;
            r_p2_data  <= mem_q;
        end
    end

    // List occupancy and overflow; cleared at line_start, held after done
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (line_start) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (list_we)                        r_cnt <= r_cnt + CW'(1);
            if ((r_p2_vis && w_full) || w_stop) r_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vid_sprite_line_scan.sv
// Directed bench for vid_sprite_line_scan with a registered attribute
// memory model; expected values are hand-derived from the cycle timing
// (cycle 0 = line_start cycle).
module tb_vid_sprite_line_scan;

    typedef struct {
        int          cyc;
        int          idx;
        int          spr;
        logic [63:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        line_start;
    logic [10:0] line_num;
    logic        mem_en;
    logic [7:0]  mem_addr;
    logic [63:0] mem_q = '0;
    logic        list_we;
    logic [3:0]  list_idx;
    logic [63:0] list_data;
    logic [7:0]  list_sprite;
    logic        busy;
    logic        done;
    logic [4:0]  count;
    logic        overflow;

    logic [63:0] mem [256];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int c0 = 0;
    int n_done = 0;
    wr_t q[$];
    logic [4:0] cnt_at1;
    logic       ovf_at1, busy_at1, busy_at258, busy_at259, en_at6;
    logic [7:0] addr_at6;

    vid_sprite_line_scan #(.NUM_SPRITES(256), .MAX_PER_LINE(16)) dut (
        .clk(clk), .reset(reset), .line_start(line_start), .line_num(line_num),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_q(mem_q),
        .list_we(list_we), .list_idx(list_idx), .list_data(list_data),
        .list_sprite(list_sprite), .busy(busy), .done(done),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) mem_q <= mem[mem_addr];
    end

    always @(negedge clk) begin
        int rel;
        rel = cyc - c0;
        if (list_we) q.push_back('{rel, int'(list_idx), int'(list_sprite), list_data});
        if (done) n_done++;
        if (rel == 1) begin cnt_at1 = count; ovf_at1 = overflow; busy_at1 = busy; end
        if (rel == 6) begin en_at6 = mem_en; addr_at6 = mem_addr; end
        if (rel == 258) busy_at258 = busy;
        if (rel == 259) busy_at259 = busy;
    end

    function automatic logic [63:0] ent(input logic [10:0] y, input logic [5:0] h,
                                        input logic en, input logic [31:0] tag);
        return {tag, en, 3'b000, h, y, 11'd33};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_line(input logic [10:0] ln);
        line_start = 1'b1;
        line_num   = ln;
        c0         = cyc;
        @(posedge clk);
        #1 line_start = 1'b0;
    endtask

    task automatic start_line(input logic [10:0] ln);
        @(posedge clk);
        #1;
        pulse_line(ln);
    endtask

    task automatic wait_done(input string tag, input int exp_rel);
        int seen;
        seen = -1;
        for (int i = 0; i < 400 && seen < 0; i++) begin
            @(negedge clk);
            if (done) seen = cyc - c0;
        end
        chk(tag, seen, exp_rel);
    endtask

    task automatic run_line(input string tag, input logic [10:0] ln, input int exp_rel);
        q.delete();
        n_done = 0;
        start_line(ln);
        wait_done(tag, exp_rel);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int ovf_done;
`ifdef SPRITE_SCAN_EARLY_STOP_EN
        ovf_done = 21;
`else
        ovf_done = 259;
`endif
        for (int i = 0; i < 256; i++) mem[i] = '0;
        reset = 1'b1; line_start = 1'b0; line_num = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_list_we", list_we, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);

        // Single visible sprite
        mem[5] = ent(11'd100, 6'd7, 1'b1, 32'hCAFE0005);
        run_line("basic_done_cyc", 11'd103, 259);
        chk("basic_nwr", q.size(), 1);
        chk("basic_wr_cyc", q.size() > 0 ? q[0].cyc : -1, 8);
        chk("basic_slot", q.size() > 0 ? q[0].idx : -1, 0);
        chk("basic_sprite", q.size() > 0 ? q[0].spr : -1, 5);
        chk("basic_data", q.size() > 0 ? q[0].data : '0, ent(11'd100, 6'd7, 1'b1, 32'hCAFE0005));
        chk("basic_count", count, 1);
        chk("basic_ovf", overflow, 0);
        chk("basic_en6", en_at6, 1);
        chk("basic_addr6", addr_at6, 5);
        chk("basic_busy1", busy_at1, 1);
        chk("basic_busy258", busy_at258, 1);
        chk("basic_busy259", busy_at259, 0);
        chk("basic_ndone", n_done, 1);
        chk("mem_addr_hold", mem_addr, 255);

        // Vertical boundaries
        run_line("bot_done", 11'd107, 259);
        chk("bot_count", count, 1);
        run_line("below_done", 11'd108, 259);
        chk("below_count", count, 0);
        chk("below_nwr", q.size(), 0);
        run_line("above_done", 11'd99, 259);
        chk("above_count", count, 0);

        // Wrap across line 2047 -> 0
        mem[5] = ent(11'd2045, 6'd4, 1'b1, 32'h0000_0055);
        run_line("wrap_done", 11'd1, 259);
        chk("wrap_count", count, 1);
        chk("wrap_sprite", q.size() > 0 ? q[0].spr : -1, 5);
        run_line("wrap_out_done", 11'd2, 259);
        chk("wrap_out_count", count, 0);
        mem[5] = ent(11'd2045, 6'd4, 1'b0, 32'h0000_0055);
        run_line("dis_done", 11'd2045, 259);
        chk("dis_count", count, 0);

        // Overflow: 20 visible sprites, 16 slots
        for (int i = 0; i < 20; i++) mem[i] = ent(11'd0, 6'd63, 1'b1, i);
        run_line("ovf_done", 11'd10, ovf_done);
        chk("ovf_nwr", q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            chk("ovf_sprite", q.size() > i ? q[i].spr : -1, i);
            chk("ovf_slot", q.size() > i ? q[i].idx : -1, i);
        end
        chk("ovf_count", count, 16);
        chk("ovf_flag", overflow, 1);

        // Restart mid-scan at cycle 100 with a new line
        mem[0] = ent(11'd200, 6'd0, 1'b1, 32'hBEEF0000);
        q.delete(); n_done = 0;
        start_line(11'd10);
        repeat (99) @(posedge clk);
        #1;
        chk("rs_pre_count", count, 16);
        chk("rs_pre_ovf", overflow, 1);
        q.delete(); n_done = 0;
        pulse_line(11'd200);
        wait_done("rs_done", 259);
        repeat (3) @(negedge clk);
        chk("rs_count_clr", cnt_at1, 0);
        chk("rs_ovf_clr", ovf_at1, 0);
        chk("rs_nwr", q.size(), 1);
        chk("rs_wr_cyc", q.size() > 0 ? q[0].cyc : -1, 3);
        chk("rs_sprite", q.size() > 0 ? q[0].spr : -1, 0);
        chk("rs_count", count, 1);
        chk("rs_ovf", overflow, 0);
        chk("rs_ndone", n_done, 1);

        // Back-to-back: new line_start in the done cycle
        q.delete(); n_done = 0;
        start_line(11'd10);
        repeat (258) @(posedge clk);
        #1;
        chk("b2b_done_hi", done, 1);
        chk("b2b_first_count", count, 16);
        q.delete();
        pulse_line(11'd200);
        chk("b2b_first_ndone", n_done, 1);
        n_done = 0;
        wait_done("b2b_done", 259);
        repeat (3) @(negedge clk);
        chk("b2b_count", count, 1);
        chk("b2b_ovf", overflow, 0);
        chk("b2b_nwr", q.size(), 1);
        chk("b2b_wr_cyc", q.size() > 0 ? q[0].cyc : -1, 3);

        // Reset mid-scan at cycle 50
        q.delete(); n_done = 0;
        start_line(11'd10);
        repeat (49) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        q.delete(); n_done = 0;
        repeat (300) @(negedge clk);
        chk("mr_nwr", q.size(), 0);
        chk("mr_ndone", n_done, 0);
        chk("mr_busy", busy, 0);
        chk("mr_mem_en", mem_en, 0);
        chk("mr_count", count, 0);
        chk("mr_ovf", overflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
